fifo_push_pop_sched: RTL and testbench

- Round-robin scheduler that shares one fifo write port among num_req requesters and paces the read port from a downstream ready signal.
- Keeps its own occupancy credit counter, so it never overflows or underflows the fifo and does not depend on the fifo's registered, one-cycle-late flags.
- Sits directly in front of the 16x8 block-RAM fifo and drives its push/pop/reset pins.

---
 rtl/fifo_push_pop_sched.sv | 86 ++++++++
 tb/tb_fifo_push_pop_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_push_pop_sched.sv
// Round-robin arbiter sharing one fifo write port among num_req requesters,
// with credit-based occupancy tracking and downstream-paced pops.
module fifo_push_pop_sched #(
  parameter int unsigned num_req    = 4,
  parameter int unsigned width_bits = 8,
  parameter int unsigned depth_len  = 16,
  parameter int unsigned depth_bits = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           arb_en,
  input  logic [num_req-1:0]             req,
  input  logic [num_req*width_bits-1:0]  req_data,
  output logic [num_req-1:0]             gnt,
  output logic                           fifo_reset,
  output logic                           fifo_push_en,
  output logic [width_bits-1:0]          fifo_di,
  output logic                           fifo_pop_en,
  input  logic                           dn_ready,
  output logic [depth_bits-1:0]          occupancy,
  output logic                           busy
);

  localparam int unsigned ptr_bits = (num_req > 1) ? $clog2(num_req) : 1;
  localparam logic [depth_bits-1:0] occ_max  = depth_bits'(depth_len - 1);
  localparam logic [ptr_bits-1:0]   ptr_init = ptr_bits'(num_req - 1);

  logic [ptr_bits-1:0]   ptr;
  logic [ptr_bits-1:0]   winner;
  logic [ptr_bits-1:0]   cand;
  logic                  can_grant;
  logic                  grant_any;
  logic                  pop_dec;
  logic [depth_bits-1:0] occ_nxt;

  // Search from the slot after the last winner, wrapping once around.
  always_comb begin
    gnt       = '0;
    winner    = ptr;
    cand      = ptr;
    grant_any = 1'b0;
    can_grant = arb_en & ~fifo_reset & (occupancy < occ_max);
    for (int unsigned k = 1; k <= num_req; k++) begin
      cand = ptr_bits'((32'(ptr) + k) % num_req);
      if (can_grant && !grant_any && req[cand]) begin
        grant_any   = 1'b1;
        winner      = cand;
        gnt[cand]   = 1'b1;
      end
    end
  end

  // Pop only words already credited; a grant this cycle is not yet poppable.
  always_comb begin
    pop_dec = dn_ready & ~fifo_reset & (occupancy != '0);
    occ_nxt = occupancy;
    case ({grant_any, pop_dec})
      2'b10:   occ_nxt = occupancy + depth_bits'(1);
      2'b01:   occ_nxt = occupancy - depth_bits'(1);
      default: occ_nxt = occupancy;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_reset   <= 1'b1;
      ptr          <= ptr_init;
      fifo_push_en <= 1'b0;
      fifo_di      <= '0;
      fifo_pop_en  <= 1'b0;
      occupancy    <= '0;
      busy         <= 1'b0;
    end else begin
      fifo_reset   <= 1'b0;
      fifo_push_en <= grant_any;
      fifo_pop_en  <= pop_dec;
      occupancy    <= occ_nxt;
      busy         <= (occ_nxt != '0) | grant_any | pop_dec;
      if (grant_any) begin
        ptr     <= winner;
        fifo_di <= req_data[32'(winner)*width_bits +: width_bits];
      end
    end
  end

endmodule

// File: tb/tb_fifo_push_pop_sched.sv
// Directed bench for fifo_push_pop_sched with a small behavioural fifo
// standing in for the block-RAM fifo on the push/pop pins.
module tb_fifo_push_pop_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        fifo_reset;
  logic        fifo_push_en;
  logic [7:0]  fifo_di;
  logic        fifo_pop_en;
  logic        dn_ready;
  logic [3:0]  occupancy;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  fifo_push_pop_sched #(
    .num_req(4), .width_bits(8), .depth_len(16), .depth_bits(4)
  ) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .req(req), .req_data(req_data),
    .gnt(gnt), .fifo_reset(fifo_reset), .fifo_push_en(fifo_push_en),
    .fifo_di(fifo_di), .fifo_pop_en(fifo_pop_en), .dn_ready(dn_ready),
    .occupancy(occupancy), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural 16x8 fifo: write on push edge, registered read with b_rdy.
  logic [7:0] mem [16];
  logic [3:0] wp = '0;
  logic [3:0] rp = '0;
  logic [7:0] b_do = '0;
  logic       b_rdy = 1'b0;
  int         last_wr_addr = -1;

  always @(posedge clk) begin
    if (fifo_reset) begin
      wp    <= '0;
      rp    <= '0;
      b_rdy <= 1'b0;
    end else begin
      if (fifo_push_en) begin
        mem[wp]      <= fifo_di;
        last_wr_addr <= int'(wp);
        wp           <= wp + 4'd1;
      end
      b_rdy <= fifo_pop_en;
      if (fifo_pop_en) begin
        b_do <= mem[rp];
        rp   <= rp + 4'd1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every word the downstream receives must be the next one the bench offered.
  always @(negedge clk) begin
    if (b_rdy) begin
      if (exp_q.size() == 0) check_eq("rd_extra", 32'd1, 32'd0);
      else check_eq("rd_data", {24'd0, b_do}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    arb_en   = 1'b1;
    req      = 4'b0000;
    req_data = 32'd0;
    dn_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    // Reset state
    check_eq("rst_fifo_reset", {31'd0, fifo_reset}, 32'd1);
    check_eq("rst_push", {31'd0, fifo_push_en}, 32'd0);
    check_eq("rst_pop", {31'd0, fifo_pop_en}, 32'd0);
    check_eq("rst_di", {24'd0, fifo_di}, 32'd0);
    check_eq("rst_occ", {28'd0, occupancy}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    req = 4'b0001;
    req_data[7:0] = 8'hA0;
    #1 check_eq("rst_gnt", {28'd0, gnt}, 32'd0);

    // Release: gnt held off until fifo_reset drops
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("rel_fifo_reset", {31'd0, fifo_reset}, 32'd1);
    check_eq("rel_gnt_inhibit", {28'd0, gnt}, 32'd0);
    step();
    check_eq("rel_fifo_reset_drop", {31'd0, fifo_reset}, 32'd0);
    check_eq("first_gnt", {28'd0, gnt}, 32'd1);
    step();
    req = 4'b0000;
    check_eq("first_push", {31'd0, fifo_push_en}, 32'd1);
    check_eq("first_di", {24'd0, fifo_di}, 32'hA0);
    check_eq("first_occ", {28'd0, occupancy}, 32'd1);
    check_eq("first_busy", {31'd0, busy}, 32'd1);

    // arb_en=0 freezes grants and the pointer
    arb_en = 1'b0;
    req    = 4'b1111;
    #1 check_eq("arb_off_gnt", {28'd0, gnt}, 32'd0);
    step();
    check_eq("arb_off_push", {31'd0, fifo_push_en}, 32'd0);
    check_eq("arb_off_occ", {28'd0, occupancy}, 32'd1);
    arb_en = 1'b1;
    #1 check_eq("arb_on_gnt", {28'd0, gnt}, 32'b0010);
    req = 4'b0000;

    // Fill with all four requesting: round-robin, exactly 15 grants
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(8'hA0 + i);
    req = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      #1 check_eq("rr_gnt", {28'd0, gnt}, 32'(1 << (k % 4)));
      exp_q.push_back(8'(8'hA0 + (k % 4)));
      step();
      check_eq("rr_di", {24'd0, fifo_di}, 32'(8'hA0 + (k % 4)));
    end
    #1;
    check_eq("full_gnt", {28'd0, gnt}, 32'd0);
    check_eq("full_occ", {28'd0, occupancy}, 32'd15);
    step();
    check_eq("no16_push", {31'd0, fifo_push_en}, 32'd0);
    check_eq("full_occ_hold", {28'd0, occupancy}, 32'd15);

    // One pop at full: no grant on the pop edge, grant resumes after
    dn_ready = 1'b1;
    #1 check_eq("full_pop_gnt", {28'd0, gnt}, 32'd0);
    step();
    dn_ready = 1'b0;
    check_eq("full_pop_en", {31'd0, fifo_pop_en}, 32'd1);
    check_eq("full_pop_occ", {28'd0, occupancy}, 32'd14);
    #1 check_eq("resume_gnt", {28'd0, gnt}, 32'b1000);
    step();
    req = 4'b0000;
    check_eq("resume_occ", {28'd0, occupancy}, 32'd15);
    check_eq("resume_pop", {31'd0, fifo_pop_en}, 32'd0);
    check_eq("resume_di", {24'd0, fifo_di}, 32'hA3);
    step();
    step();

    // Empty boundary: pop follows the grant by one edge, never underflows
    do_reset();
    dn_ready = 1'b1;
    req = 4'b0001;
    req_data[7:0] = 8'h3C;
    exp_q.push_back(8'h3C);
    #1 check_eq("empty_gnt", {28'd0, gnt}, 32'd1);
    step();
    req = 4'b0000;
    check_eq("empty_push", {31'd0, fifo_push_en}, 32'd1);
    check_eq("empty_no_pop", {31'd0, fifo_pop_en}, 32'd0);
    check_eq("empty_occ1", {28'd0, occupancy}, 32'd1);
    step();
    check_eq("empty_pop", {31'd0, fifo_pop_en}, 32'd1);
    check_eq("empty_occ0", {28'd0, occupancy}, 32'd0);
    step();
    check_eq("empty_pop_done", {31'd0, fifo_pop_en}, 32'd0);
    check_eq("empty_b_rdy", {31'd0, b_rdy}, 32'd1);
    check_eq("empty_b_do", {24'd0, b_do}, 32'h3C);
    step();
    check_eq("empty_occ_hold", {28'd0, occupancy}, 32'd0);
    check_eq("empty_drained", 32'(exp_q.size()), 32'd0);
    check_eq("empty_idle", {31'd0, busy}, 32'd0);
    dn_ready = 1'b0;

    // Steady state at occupancy 5: simultaneous grant and pop
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      req_data[7:0] = 8'(8'hE0 + i);
      exp_q.push_back(8'(8'hE0 + i));
      step();
    end
    check_eq("steady_fill_occ", {28'd0, occupancy}, 32'd5);
    dn_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_data[7:0] = 8'(i);
      exp_q.push_back(8'(i));
      step();
      check_eq("steady_occ", {28'd0, occupancy}, 32'd5);
      check_eq("steady_push_pop", {30'd0, fifo_push_en, fifo_pop_en}, 32'b11);
    end
    req = 4'b0000;
    for (int i = 0; i < 20; i++) step();
    check_eq("steady_drain_occ", {28'd0, occupancy}, 32'd0);
    check_eq("steady_drain_pop", {31'd0, fifo_pop_en}, 32'd0);
    check_eq("steady_drained", 32'(exp_q.size()), 32'd0);
    dn_ready = 1'b0;

    // Mid-stream reset at occupancy 7
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      req_data[7:0] = 8'(8'h10 + i);
      step();
    end
    req = 4'b0000;
    check_eq("mid_occ7", {28'd0, occupancy}, 32'd7);
    step();
    #2 reset = 1'b0;
    #1;
    check_eq("mid_fifo_reset", {31'd0, fifo_reset}, 32'd1);
    check_eq("mid_push", {31'd0, fifo_push_en}, 32'd0);
    check_eq("mid_pop", {31'd0, fifo_pop_en}, 32'd0);
    check_eq("mid_occ", {28'd0, occupancy}, 32'd0);
    check_eq("mid_di", {24'd0, fifo_di}, 32'd0);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    req = 4'b0001;
    req_data[7:0] = 8'h5A;
    #1 check_eq("mid_gnt", {28'd0, gnt}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_eq("mid_rel_gnt", {28'd0, gnt}, 32'd0);
    step();
    check_eq("mid_restart_gnt", {28'd0, gnt}, 32'd1);
    step();
    req = 4'b0000;
    check_eq("mid_restart_push", {31'd0, fifo_push_en}, 32'd1);
    check_eq("mid_restart_di", {24'd0, fifo_di}, 32'h5A);
    check_eq("mid_restart_occ", {28'd0, occupancy}, 32'd1);
    step();
    check_eq("mid_wr_addr0", 32'(last_wr_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
